// File: rtl/mmio_pkg.sv
// ============================================================================
// Module : mmio_pkg
// Brief  : Shared I/O base, register offsets and STATUS bit positions.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mmio_pkg;

    localparam logic [7:0]  c_IO_BASE         = 8'hFF;
    localparam logic [15:0] c_OFF_IR_DATA     = 16'h0000;
    localparam logic [15:0] c_OFF_SERVO_POS   = 16'h0001;
    localparam logic [15:0] c_OFF_STATUS      = 16'h0002;
    localparam int          c_STATUS_IR_NEW   = 0;
    localparam int          c_STATUS_PWM      = 1;
    localparam logic [7:0]  c_SERVO_POS_RESET = 8'd128;

endpackage

`default_nettype wire

// File: rtl/mmio_bridge_servo_pwm.sv
// ============================================================================
// Module : servo_pwm
// Brief  : Frame counter and pulse comparator for a 1-2 ms servo pulse.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module servo_pwm
    import mmio_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int PWM_HZ = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_pos,
    output logic       o_pwm
);

    localparam int          c_FRAME = CLK_HZ / PWM_HZ;
    localparam int          c_CNT_W = $clog2(c_FRAME);
    localparam logic [31:0] c_BASE  = 32'(CLK_HZ / 1000);
    localparam logic [31:0] c_STEP  = 32'(CLK_HZ / 255000);

    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_FRAME - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic [7:0]         r_shadow;
    logic [7:0]         w_pos_eff;
    logic [31:0]        w_thr;

    // The position is sampled at count 0 and held for the whole frame.
    assign w_pos_eff = (r_cnt == '0) ? i_pos : r_shadow;
    assign w_thr     = c_BASE + 32'(w_pos_eff) * c_STEP;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_shadow <= c_SERVO_POS_RESET;
            o_pwm    <= 1'b0;
        end else begin
            r_cnt    <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
            r_shadow <= w_pos_eff;
            o_pwm    <= (32'(r_cnt) < w_thr);
        end
    end

endmodule

`default_nettype wire

// File: rtl/mmio_bridge.sv
// ============================================================================
// Module : mmio_bridge
// Brief  : Core-to-RAM/I/O bridge with IR capture and servo register.
//          Servo PWM generator is built only when SERVO_PWM_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mmio_bridge #(
    parameter int CLK_HZ = 50000000,
    parameter int PWM_HZ = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] mem_addr,
    input  logic        write_en,
    input  logic [15:0] data_from_core_to_mem,
    output logic [15:0] data_from_mem,
    output logic [23:0] ram_addr,
    output logic        ram_we,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    input  logic [7:0]  ir_in,
    input  logic        ir_strobe,
    output logic        servo_pwm
);

    import mmio_pkg::*;

    logic        w_is_io;
    logic [15:0] w_io_off;
    logic        w_io_wr;
    logic        w_status_rd;
    logic        w_stb_edge;
    logic        w_pwm;
    logic [15:0] w_status;
    logic [15:0] w_io_rdata;

    logic        r_io_sel;
    logic [15:0] r_io_rdata;
    logic [7:0]  r_ir_s1;
    logic [7:0]  r_ir_s2;
    logic        r_stb_s1;
    logic        r_stb_s2;
    logic        r_stb_d;
    logic [7:0]  r_ir_data;
    logic        r_ir_new;
    logic [7:0]  r_servo_pos;

    if (CLK_HZ < 255000 || PWM_HZ < 1) begin : g_bad_cfg
        $error("mmio_bridge: CLK_HZ must be >= 255000 and PWM_HZ >= 1");
    end

    assign w_is_io     = (mem_addr[23:16] == c_IO_BASE);
    assign w_io_off    = mem_addr[15:0];
    assign w_io_wr     = write_en & w_is_io;
    assign w_status_rd = ~write_en & w_is_io & (w_io_off == c_OFF_STATUS);
    assign w_stb_edge  = r_stb_s2 & ~r_stb_d;

    assign ram_addr  = mem_addr;
    assign ram_wdata = data_from_core_to_mem;
    assign ram_we    = write_en & ~w_is_io;

    // Select is registered so the mux lines up with the RAM's 1-cycle latency.
    assign data_from_mem = r_io_sel ? r_io_rdata : ram_rdata;

`ifdef SERVO_PWM_EN
    servo_pwm #(
        .CLK_HZ (CLK_HZ),
        .PWM_HZ (PWM_HZ)
    ) u_servo_pwm (
        .clk   (clk),
        .rst   (rst),
        .i_pos (r_servo_pos),
        .o_pwm (w_pwm)
    );
`else
    assign w_pwm = 1'b0;
`endif

    assign servo_pwm = w_pwm;

    always_comb begin
        w_status                  = '0;
        w_status[c_STATUS_IR_NEW] = r_ir_new;
        w_status[c_STATUS_PWM]    = w_pwm;
        w_io_rdata                = '0;
        case (w_io_off)
            c_OFF_IR_DATA:   w_io_rdata = {8'h00, r_ir_data};
            c_OFF_SERVO_POS: w_io_rdata = {8'h00, r_servo_pos};
            c_OFF_STATUS:    w_io_rdata = w_status;
            default:         w_io_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Selecting the I/O path with zeroed data forces a 0 read after reset.
            r_io_sel    <= 1'b1;
            r_io_rdata  <= '0;
            r_ir_s1     <= '0;
            r_ir_s2     <= '0;
            r_stb_s1    <= 1'b0;
            r_stb_s2    <= 1'b0;
            r_stb_d     <= 1'b0;
            r_ir_data   <= '0;
            r_ir_new    <= 1'b0;
            r_servo_pos <= c_SERVO_POS_RESET;
        end else begin
            r_io_sel   <= w_is_io;
            r_io_rdata <= w_io_rdata;
            r_ir_s1    <= ir_in;
            r_ir_s2    <= r_ir_s1;
            r_stb_s1   <= ir_strobe;
            r_stb_s2   <= r_stb_s1;
            r_stb_d    <= r_stb_s2;

            if (w_stb_edge) begin
                r_ir_data <= r_ir_s2;
            end

            // A new sample beats a coincident STATUS read clear.
            if (w_stb_edge) begin
                r_ir_new <= 1'b1;
            end else if (w_status_rd) begin
                r_ir_new <= 1'b0;
            end

            if (w_io_wr && (w_io_off == c_OFF_SERVO_POS)) begin
                r_servo_pos <= data_from_core_to_mem[7:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mmio_bridge.sv
// ============================================================================
// Module : tb_mmio_bridge
// Brief  : Self-checking bench for mmio_bridge with a reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mmio_bridge;

    localparam int          CLK_HZ = 255000;
    localparam int          PWM_HZ = 50;
    localparam int          FRAME  = CLK_HZ / PWM_HZ;
    localparam logic [23:0] IDLE   = 24'hFF0010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] mem_addr = IDLE;
    logic        write_en = 1'b0;
    logic [15:0] data_from_core_to_mem = 16'h0000;
    logic [15:0] data_from_mem;
    logic [23:0] ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata = 16'h0000;
    logic [7:0]  ir_in = 8'h00;
    logic        ir_strobe = 1'b0;
    logic        servo_pwm;

    int n_checks = 0;
    int n_pass   = 0;

    mmio_bridge #(.CLK_HZ(CLK_HZ), .PWM_HZ(PWM_HZ)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .mem_addr              (mem_addr),
        .write_en              (write_en),
        .data_from_core_to_mem (data_from_core_to_mem),
        .data_from_mem         (data_from_mem),
        .ram_addr              (ram_addr),
        .ram_we                (ram_we),
        .ram_wdata             (ram_wdata),
        .ram_rdata             (ram_rdata),
        .ir_in                 (ir_in),
        .ir_strobe             (ir_strobe),
        .servo_pwm             (servo_pwm)
    );

    always #5 clk = ~clk;

    // External synchronous RAM, 1-cycle read latency, read-before-write.
    logic [15:0] ram_mem [logic [23:0]];
    always @(posedge clk) begin
        ram_rdata <= ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : 16'h0000;
        if (ram_we) ram_mem[ram_addr] = ram_wdata;
    end

    // Reference state.
    logic [15:0] ref_mem [logic [23:0]];
    logic [7:0]  m_pos     = 8'd128;
    logic [7:0]  m_ir_data = 8'h00;
    logic        m_ir_new  = 1'b0;
    logic        m_pwm     = 1'b0;
    int          m_phase   = 0;
    int          m_width   = 0;

    // Servo position register and the expected pulse level, frame by frame.
    always @(posedge clk) begin
        if (rst) begin
            m_pos   = 8'd128;
            m_phase = 0;
            m_width = 0;
            m_pwm   = 1'b0;
        end else begin
            if (m_phase == 0) m_width = CLK_HZ / 1000 + int'(m_pos) * (CLK_HZ / 255000);
            m_pwm   = (m_phase < m_width);
            m_phase = (m_phase == FRAME - 1) ? 0 : m_phase + 1;
            if (write_en && mem_addr == 24'hFF0001) m_pos = data_from_core_to_mem[7:0];
        end
    end

    function automatic logic [15:0] ref_rd(input logic [23:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    endfunction

    function automatic logic [15:0] exp_status();
`ifdef SERVO_PWM_EN
        return {14'h0000, m_pwm, m_ir_new};
`else
        return {14'h0000, 1'b0, m_ir_new};
`endif
    endfunction

    function automatic logic [23:0] pool(input int i);
        return (i < 8) ? 24'h002800 + 24'(i) : 24'hFEFFF0 + 24'(i);
    endfunction

    task automatic put(input logic [23:0] a, input logic we, input logic [15:0] d);
        mem_addr = a;
        write_en = we;
        data_from_core_to_mem = d;
    endtask

    task automatic test_reset();
        logic [15:0] e;
        put(24'hFF0000, 1'b0, 16'h0000);
        repeat (3) @(negedge clk);
        n_checks++; if (data_from_mem !== 16'h0000) $display("FAIL rst_data got %h want 0000", data_from_mem); else n_pass++;
        n_checks++; if (servo_pwm !== 1'b0) $display("FAIL rst_pwm got %b want 0", servo_pwm); else n_pass++;
        n_checks++; if (ram_we !== 1'b0 || ram_addr !== 24'hFF0000) $display("FAIL rst_ram got we=%b addr=%h want we=0 addr=ff0000", ram_we, ram_addr); else n_pass++;
        rst = 1'b0;
        put(24'hFF0001, 1'b0, 16'h0000);
        @(negedge clk);
        n_checks++; if (data_from_mem !== 16'h0080) $display("FAIL rst_servo_pos got %h want 0080", data_from_mem); else n_pass++;
        put(24'hFF0002, 1'b0, 16'h0000);
        e = exp_status();
        m_ir_new = 1'b0;
        @(negedge clk);
        n_checks++; if (data_from_mem !== e) $display("FAIL rst_status got %h want %h", data_from_mem, e); else n_pass++;
        put(IDLE, 1'b0, 16'h0000);
    endtask

    task automatic test_ram_rw();
        @(negedge clk);
        put(24'h002800, 1'b1, 16'hBEEF);
        ref_mem[24'h002800] = 16'hBEEF;
        #1;
        n_checks++; if (ram_we !== 1'b1 || ram_addr !== 24'h002800 || ram_wdata !== 16'hBEEF)
            $display("FAIL ram_write got we=%b addr=%h wd=%h want 1/002800/beef", ram_we, ram_addr, ram_wdata); else n_pass++;
        @(negedge clk);
        put(24'h002800, 1'b0, 16'h0000);
        #1;
        n_checks++; if (ram_we !== 1'b0) $display("FAIL ram_we_pulse got %b want 0", ram_we); else n_pass++;
        @(negedge clk);
        n_checks++; if (data_from_mem !== 16'hBEEF) $display("FAIL ram_read got %h want beef", data_from_mem); else n_pass++;
        put(IDLE, 1'b0, 16'h0000);
    endtask

    task automatic test_ir();
        logic [15:0] e;
        ir_in = 8'h5A;
        @(negedge clk);
        ir_strobe = 1'b1;
        repeat (4) @(negedge clk);
        ir_strobe = 1'b0;
        repeat (4) @(negedge clk);
        m_ir_new  = 1'b1;
        m_ir_data = 8'h5A;
        put(24'hFF0002, 1'b0, 16'h0000);
        e = exp_status();
        m_ir_new = 1'b0;
        @(negedge clk);
        n_checks++; if (data_from_mem !== e || data_from_mem[0] !== 1'b1) $display("FAIL ir_status_set got %h want %h", data_from_mem, e); else n_pass++;
        put(24'hFF0000, 1'b0, 16'h0000);
        @(negedge clk);
        n_checks++; if (data_from_mem !== 16'h005A) $display("FAIL ir_data got %h want 005a", data_from_mem); else n_pass++;
        put(24'hFF0002, 1'b0, 16'h0000);
        e = exp_status();
        @(negedge clk);
        n_checks++; if (data_from_mem !== e || data_from_mem[0] !== 1'b0) $display("FAIL ir_status_clr got %h want %h", data_from_mem, e); else n_pass++;
        put(IDLE, 1'b0, 16'h0000);
    endtask

    // STATUS read lands on the cycle the 2-stage synchronised strobe rises.
    task automatic test_status_race();
        logic [15:0] e;
        ir_in = 8'hC3;
        @(negedge clk);
        ir_strobe = 1'b1;
        @(negedge clk);
        @(negedge clk);
        put(24'hFF0002, 1'b0, 16'h0000);
        e = exp_status();
        m_ir_new  = 1'b1;
        m_ir_data = 8'hC3;
        @(negedge clk);
        n_checks++; if (data_from_mem !== e || data_from_mem[0] !== 1'b0) $display("FAIL race_read got %h want %h", data_from_mem, e); else n_pass++;
        put(24'hFF0002, 1'b0, 16'h0000);
        e = exp_status();
        m_ir_new = 1'b0;
        @(negedge clk);
        n_checks++; if (data_from_mem !== e || data_from_mem[0] !== 1'b1) $display("FAIL race_set_wins got %h want %h", data_from_mem, e); else n_pass++;
        ir_strobe = 1'b0;
        put(24'hFF0000, 1'b0, 16'h0000);
        @(negedge clk);
        n_checks++; if (data_from_mem !== 16'h00C3) $display("FAIL race_ir_data got %h want 00c3", data_from_mem); else n_pass++;
        put(IDLE, 1'b0, 16'h0000);
    endtask

    task automatic test_unmapped();
        @(negedge clk);
        put(24'hFF0010, 1'b1, 16'h1234);
        #1;
        n_checks++; if (ram_we !== 1'b0) $display("FAIL unmapped_we got %b want 0", ram_we); else n_pass++;
        @(negedge clk);
        put(24'hFF0010, 1'b0, 16'h0000);
        #1;
        n_checks++; if (ram_we !== 1'b0) $display("FAIL unmapped_rd_we got %b want 0", ram_we); else n_pass++;
        @(negedge clk);
        n_checks++; if (data_from_mem !== 16'h0000) $display("FAIL unmapped_read got %h want 0000", data_from_mem); else n_pass++;
        put(IDLE, 1'b0, 16'h0000);
    endtask

    task automatic test_random();
        logic        pend;
        logic [15:0] pexp;
        logic [23:0] a;
        logic        we;
        logic [15:0] d;
        logic [15:0] offs [3];
        offs[0] = 16'h0003; offs[1] = 16'h0010; offs[2] = 16'hFFFF;
        pend = 1'b0;
        pexp = 16'h0000;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (pend) begin
                n_checks++; if (data_from_mem !== pexp) $display("FAIL rand_read[%0d] got %h want %h", i, data_from_mem, pexp); else n_pass++;
            end
            d    = 16'($urandom);
            we   = 1'b0;
            pend = 1'b0;
            pexp = 16'h0000;
            case ($urandom_range(0, 10))
                0, 1, 2: begin a = pool($urandom_range(0, 15)); we = 1'b1; ref_mem[a] = d; end
                3, 4:    begin a = pool($urandom_range(0, 15)); pexp = ref_rd(a); pend = 1'b1; end
                5:       begin a = 24'hFF0001; we = 1'b1; end
                6:       begin a = 24'hFF0001; pexp = {8'h00, m_pos}; pend = 1'b1; end
                7:       begin a = 24'hFF0000; pexp = {8'h00, m_ir_data}; pend = 1'b1; end
                8:       begin a = 24'hFF0002; pexp = exp_status(); m_ir_new = 1'b0; pend = 1'b1; end
                9:       begin a = {8'hFF, offs[$urandom_range(0, 2)]}; we = 1'($urandom); pend = ~we; end
                default: begin a = 24'hFF0000; we = 1'b1; end
            endcase
            put(a, we, d);
            #1;
            n_checks++; if (ram_we !== (we && a[23:16] != 8'hFF)) $display("FAIL rand_we[%0d] got %b addr %h", i, ram_we, a); else n_pass++;
            n_checks++; if (ram_addr !== a || ram_wdata !== d) $display("FAIL rand_pass[%0d] got %h/%h want %h/%h", i, ram_addr, ram_wdata, a, d); else n_pass++;
        end
        @(negedge clk);
        if (pend) begin
            n_checks++; if (data_from_mem !== pexp) $display("FAIL rand_read_last got %h want %h", data_from_mem, pexp); else n_pass++;
        end
        put(IDLE, 1'b0, 16'h0000);
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        put(24'hFF0001, 1'b1, 16'h0033);
        @(negedge clk);
        put(24'hFF0001, 1'b0, 16'h0000);
        rst = 1'b1;
        m_ir_new  = 1'b0;
        m_ir_data = 8'h00;
        @(negedge clk);
        n_checks++; if (data_from_mem !== 16'h0000) $display("FAIL inflight_discard got %h want 0000", data_from_mem); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (data_from_mem !== 16'h0080) $display("FAIL inflight_servo_pos got %h want 0080", data_from_mem); else n_pass++;
        put(24'hFF0000, 1'b0, 16'h0000);
        @(negedge clk);
        n_checks++; if (data_from_mem !== 16'h0000) $display("FAIL inflight_ir_data got %h want 0000", data_from_mem); else n_pass++;
        put(IDLE, 1'b0, 16'h0000);
    endtask

    task automatic test_pwm();
        int hi0;
        int hi1;
        int e0;
        int e1;
        hi0 = 0;
        hi1 = 0;
`ifdef SERVO_PWM_EN
        e0 = 383;
        e1 = 510;
`else
        e0 = 0;
        e1 = 0;
`endif
        put(IDLE, 1'b0, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= FRAME; n++) begin
            @(negedge clk);
            if (servo_pwm === 1'b1) hi0++;
            if (n == 1000) put(24'hFF0001, 1'b1, 16'hFFFF);
            if (n == 1001) put(IDLE, 1'b0, 16'h0000);
        end
        for (int n = 1; n <= FRAME; n++) begin
            @(negedge clk);
            if (servo_pwm === 1'b1) hi1++;
        end
        n_checks++; if (hi0 !== e0) $display("FAIL pwm_frame0_width got %0d want %0d", hi0, e0); else n_pass++;
        n_checks++; if (hi1 !== e1) $display("FAIL pwm_frame1_width got %0d want %0d", hi1, e1); else n_pass++;
        put(24'hFF0001, 1'b0, 16'h0000);
        @(negedge clk);
        n_checks++; if (data_from_mem !== 16'h00FF) $display("FAIL pwm_servo_pos got %h want 00ff", data_from_mem); else n_pass++;
        put(IDLE, 1'b0, 16'h0000);
    endtask

    initial begin
        test_reset();
        test_ram_rw();
        test_ir();
        test_status_race();
        test_unmapped();
        test_random();
        test_reset_inflight();
        test_pwm();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mmio_bridge.md
MMIO_BRIDGE -- requirements
Module: mmio_bridge

Interface
- REQ-001 SHALL have parameter CLK_HZ, default 50000000, clock frequency in Hz.
- REQ-002 SHALL have parameter PWM_HZ, default 50, servo frame rate.
- REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
- REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
- REQ-005 SHALL have port mem_addr, input, 24, word address from core.
- REQ-006 SHALL have port write_en, input, 1, core write strobe, one word per cycle while high.
- REQ-007 SHALL have port data_from_core_to_mem, input, 16, core write data.
- REQ-008 SHALL have port data_from_mem, output, 16, read data returned to core.
- REQ-009 SHALL have ports ram_addr (output, 24), ram_we (output, 1), ram_wdata (output, 16) and ram_rdata (input, 16) to a synchronous RAM with 1-cycle read latency.
- REQ-010 SHALL have port ir_in, input, 8, asynchronous IR sensor value.
- REQ-011 SHALL have port ir_strobe, input, 1, asynchronous new-sample pulse from the sensor, at least 3 clk wide.
- REQ-012 SHALL have port servo_pwm, output, 1, servo control pulse.

Function
- REQ-013 SHALL decode mem_addr[23:16]==8'hFF as I/O space and every other address as RAM space.
- REQ-014 SHALL drive ram_addr=mem_addr, ram_wdata=data_from_core_to_mem and ram_we=write_en&RAM-space, all combinationally.
- REQ-015 SHALL present read data for any address on data_from_mem exactly 1 cycle after the address, matching core fetch->decode timing; the space select SHALL be registered.
- REQ-016 SHALL pass RAM data unmodified, with no byte swap; the core performs the swap.
- REQ-017 SHALL map I/O offset 0x0000 as IR_DATA: read-only, {8'h00, latched IR sample}.
- REQ-018 SHALL map I/O offset 0x0001 as SERVO_POS: read/write, bits [7:0]; upper write bits ignored, upper read bits 0.
- REQ-019 SHALL map I/O offset 0x0002 as STATUS: read-only, bit0 ir_new, bit1 current servo_pwm level, other bits 0.
- REQ-020 SHALL return 16'h0000 for reads of unmapped I/O offsets and ignore writes to them.
- REQ-021 SHALL synchronize ir_in and ir_strobe through 2 flip-flops each.
- REQ-022 SHALL, on a rising edge of the synchronized strobe, latch the synchronized ir_in into IR_DATA and set ir_new.
- REQ-023 SHALL clear ir_new on the cycle after a STATUS read; the read returns the pre-clear value.
- REQ-024 SHALL keep ir_new set when a new-sample edge coincides with a STATUS read clear; set wins.
- REQ-025 SHALL run a frame counter 0..(CLK_HZ/PWM_HZ)-1 that wraps to 0.
- REQ-026 SHALL drive servo_pwm high while counter < CLK_HZ/1000 + shadow_pos*(CLK_HZ/255000), giving a 1-2 ms pulse.
- REQ-027 SHALL copy SERVO_POS into shadow_pos only when the counter is 0; a mid-frame write affects the next frame.
- REQ-028 SHALL register servo_pwm, so it has no glitches.

Reset
- REQ-029 SHALL, on rst, set data_from_mem=0, IR_DATA=0, ir_new=0, SERVO_POS=shadow_pos=8'd128, counter=0 and servo_pwm=0.
- REQ-030 SHALL discard an in-flight read when rst is asserted mid-access; data_from_mem reads 0 on the cycle after reset.

Configuration
- REQ-031 SHALL, with SERVO_PWM_EN defined, instantiate the PWM generator as in REQ-025..028.
- REQ-032 SHALL, without SERVO_PWM_EN, tie servo_pwm to 0 and read STATUS bit1 as 0; SERVO_POS remains read/write.

Structure
- REQ-033 SHALL place the I/O base 8'hFF, the register offsets and the STATUS bit positions in shared package mmio_pkg.
- REQ-034 SHALL implement the frame counter and comparator as sub-module servo_pwm.

Verification
- REQ-035 SHALL cover: write 0xBEEF to 0x002800, then read it -> ram_we pulses 1 cycle; data_from_mem=0xBEEF one cycle after the read address.
- REQ-036 SHALL cover: ir_in=0x5A, 4-cycle ir_strobe pulse, then read 0xFF0002 and 0xFF0000 -> STATUS=0x0001 then 0x0000 on re-read; IR_DATA=0x005A.
- REQ-037 SHALL cover: STATUS read in the same cycle as the synchronized strobe edge -> read returns 0; ir_new=1 afterwards.
- REQ-038 SHALL cover: CLK_HZ=255000, PWM_HZ=50 (frame 5100), write SERVO_POS=255 mid-frame -> current frame high width 383, next frame 510.
- REQ-039 SHALL cover: rst asserted with a read pending from 0xFF0001 -> data_from_mem=0, SERVO_POS reads 0x0080.
- REQ-040 SHALL cover: read/write 0xFF0010 -> read 0x0000; ram_we stays 0.
